// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared types and helpers for the system bus arbiter.
//   state_e         - arbiter FSM state (StIdle, StBusy)
//   MAX_MASTERS     - upper bound on the number of masters
//   idx_t           - master index wide enough for MAX_MASTERS
//   onehot_to_idx() - one-hot vector to master index
package bus_arbiter_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned IDX_W       = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  // Returns the index of the set bit; zero for an all-zero vector.
  function automatic idx_t onehot_to_idx(input logic [MAX_MASTERS-1:0] onehot);
    idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (onehot[i]) begin
        idx = idx | idx_t'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: master-side and slave-side signals of the shared system bus.
//   i_m_cs/i_m_we/i_m_addr/i_m_dat - per-master request, packed per master
//   o_m_ack/o_m_err/o_m_dat         - per-master ack, timeout error, read data
//   o_grant                         - registered one-hot grant
//   o_s_cs/o_s_we/o_s_addr/o_s_dat  - muxed request towards the slave
//   i_s_dat/i_s_ack                 - slave read data and single-cycle ack
// Modport slave is the arbiter's view; modport master is the system/bench view.
interface bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8
);

  logic [NUM_MASTERS-1:0]        i_m_cs;
  logic [NUM_MASTERS-1:0]        i_m_we;
  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] i_m_dat;
  logic [NUM_MASTERS-1:0]        o_m_ack;
  logic [NUM_MASTERS-1:0]        o_m_err;
  logic [DATA_W-1:0]             o_m_dat;
  logic [NUM_MASTERS-1:0]        o_grant;
  logic                          o_s_cs;
  logic                          o_s_we;
  logic [ADDR_W-1:0]             o_s_addr;
  logic [DATA_W-1:0]             o_s_dat;
  logic [DATA_W-1:0]             i_s_dat;
  logic                          i_s_ack;

  modport slave (
    input  i_m_cs, i_m_we, i_m_addr, i_m_dat, i_s_dat, i_s_ack,
    output o_m_ack, o_m_err, o_m_dat, o_grant, o_s_cs, o_s_we, o_s_addr, o_s_dat
  );

  modport master (
    output i_m_cs, i_m_we, i_m_addr, i_m_dat, i_s_dat, i_s_ack,
    input  o_m_ack, o_m_err, o_m_dat, o_grant, o_s_cs, o_s_we, o_s_addr, o_s_dat
  );

endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
//   i_req    - request vector (WIDTH bits, local indices 0..WIDTH-1)
//   i_ptr    - local index of the last winner; search starts at i_ptr+1 and wraps
//   o_onehot - one-hot winner, zero if nothing requests
//   o_idx    - local index of the winner
//   o_valid  - some request was found
module rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] i_req,
  input  idx_t             i_ptr,
  output logic [WIDTH-1:0] o_onehot,
  output idx_t             o_idx,
  output logic             o_valid
);

  logic [MAX_MASTERS-1:0] req_ext;
  logic [MAX_MASTERS-1:0] oh_ext;
  logic [IDX_W:0]         cand;

  // Scan WIDTH candidates starting just after the pointer; first hit wins.
  always_comb begin
    req_ext = MAX_MASTERS'(i_req);
    oh_ext  = '0;
    o_valid = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= WIDTH; i++) begin
      cand = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(WIDTH)) begin
        cand = cand - (IDX_W+1)'(WIDTH);
      end
      if (!o_valid && req_ext[cand[IDX_W-1:0]]) begin
        oh_ext[cand[IDX_W-1:0]] = 1'b1;
        o_valid                 = 1'b1;
      end
    end
  end

  assign o_onehot = oh_ext[WIDTH-1:0];
  assign o_idx    = onehot_to_idx(oh_ext);

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: N-master, single-slave system bus arbiter.
// Master 0 (video fetch) has absolute priority; masters 1..N-1 share the bus
// round-robin. A grant is held for one transaction and released on slave ack,
// on master abort (cs dropped) or, when compiled in, on timeout.
//   i_clk   - system clock
//   i_reset - synchronous, active-high reset
//   bus     - bus_arbiter_if.slave: master requests, slave side, grant, acks
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to add the no-ack timeout
// (TIMEOUT_CYCLES); otherwise o_m_err is tied low and BUSY waits indefinitely.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic        i_clk,
  input logic        i_reset,
  bus_arbiter_if.slave bus
);

  localparam int unsigned NUM_LOW = NUM_MASTERS - 1;

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
    $error("bus_arbiter: NUM_MASTERS out of range 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_e                 state_q;
  idx_t                   g_q;
  idx_t                   rr_q;
  logic [NUM_MASTERS-1:0] grant_q;

  // Per-master views padded to MAX_MASTERS so a 3-bit index always fits.
  logic [MAX_MASTERS-1:0] cs_ext;
  logic [MAX_MASTERS-1:0] we_ext;
  logic [ADDR_W-1:0]      addr_arr [MAX_MASTERS];
  logic [DATA_W-1:0]      dat_arr  [MAX_MASTERS];

  assign cs_ext = MAX_MASTERS'(bus.i_m_cs);
  assign we_ext = MAX_MASTERS'(bus.i_m_we);

  for (genvar k = 0; k < MAX_MASTERS; k++) begin : g_unpack
    if (k < NUM_MASTERS) begin : g_used
      assign addr_arr[k] = bus.i_m_addr[k*ADDR_W +: ADDR_W];
      assign dat_arr[k]  = bus.i_m_dat[k*DATA_W +: DATA_W];
    end else begin : g_pad
      assign addr_arr[k] = '0;
      assign dat_arr[k]  = '0;
    end
  end

  // Round-robin among the low masters; picker works in local indices 0..N-2.
  logic [NUM_LOW-1:0] low_onehot;
  idx_t               low_idx;
  logic               low_valid;
  idx_t               low_ptr;

  assign low_ptr = rr_q - idx_t'(1);

  rr_picker #(
    .WIDTH (NUM_LOW)
  ) u_rr_picker (
    .i_req    (bus.i_m_cs[NUM_MASTERS-1:1]),
    .i_ptr    (low_ptr),
    .o_onehot (low_onehot),
    .o_idx    (low_idx),
    .o_valid  (low_valid)
  );

  logic busy;
  logic ack_pass;
  logic timeout_hit;
  idx_t sel;

  assign busy     = (state_q == StBusy);
  assign ack_pass = busy && bus.i_s_ack && !i_reset;
  // In IDLE the slave address/data mirror master 0 so they stay deterministic.
  assign sel      = busy ? g_q : '0;

`ifdef BUS_ARBITER_TIMEOUT_EN
  logic [15:0] cnt_q;
  assign timeout_hit = busy && !bus.i_s_ack && !i_reset &&
                       (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  logic [MAX_MASTERS-1:0] ack_ext;
  logic [MAX_MASTERS-1:0] err_ext;

  always_comb begin
    ack_ext = '0;
    err_ext = '0;
    if (ack_pass) begin
      ack_ext[g_q] = 1'b1;
    end
    if (timeout_hit) begin
      err_ext[g_q] = 1'b1;
    end
  end

  assign bus.o_m_ack  = ack_ext[NUM_MASTERS-1:0];
  assign bus.o_m_err  = err_ext[NUM_MASTERS-1:0];
  assign bus.o_m_dat  = bus.i_s_dat;
  assign bus.o_grant  = grant_q;
  assign bus.o_s_cs   = busy && cs_ext[g_q];
  assign bus.o_s_we   = busy && we_ext[g_q];
  assign bus.o_s_addr = addr_arr[sel];
  assign bus.o_s_dat  = dat_arr[sel];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      g_q     <= '0;
      rr_q    <= idx_t'(NUM_MASTERS - 1);
      grant_q <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (cs_ext[0]) begin
            // Master 0 overrides round-robin and leaves rr untouched.
            state_q <= StBusy;
            g_q     <= '0;
            grant_q <= NUM_MASTERS'(1);
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end else if (low_valid) begin
            state_q <= StBusy;
            g_q     <= low_idx + idx_t'(1);
            rr_q    <= low_idx + idx_t'(1);
            grant_q <= {low_onehot, 1'b0};
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        StBusy: begin
          if (bus.i_s_ack || !cs_ext[g_q] || timeout_hit) begin
            state_q <= StIdle;
            grant_q <= '0;
          end
`ifdef BUS_ARBITER_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed test of bus_arbiter with NUM_MASTERS=3 and
// TIMEOUT_CYCLES=4. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
module tb_bus_arbiter;

  localparam int unsigned NM = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_arbiter #(
    .NUM_MASTERS    (NM),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.i_m_cs   = '0;
    bus.i_m_we   = '0;
    bus.i_m_addr = '0;
    bus.i_m_dat  = '0;
    bus.i_s_dat  = '0;
    bus.i_s_ack  = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  logic [NM-1:0] rr_exp [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rr_exp = '{3'b010, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    sample();
    check("reset grant", 32'(bus.o_grant), 32'h0);
    check("reset s_cs", 32'(bus.o_s_cs), 32'h0);
    check("reset s_we", 32'(bus.o_s_we), 32'h0);
    check("reset ack", 32'(bus.o_m_ack), 32'h0);
    check("reset err", 32'(bus.o_m_err), 32'h0);

    // Single write from master 1, slave acks two cycles after cs.
    step();
    bus.i_m_cs            = 3'b010;
    bus.i_m_we            = 3'b010;
    bus.i_m_addr[AW +: AW] = 16'h1234;
    bus.i_m_dat[DW +: DW]  = 8'h5A;
    sample();
    check("single t grant", 32'(bus.o_grant), 32'h0);
    step();
    sample();
    check("single t+1 grant", 32'(bus.o_grant), 32'h2);
    check("single t+1 s_cs", 32'(bus.o_s_cs), 32'h1);
    check("single t+1 s_we", 32'(bus.o_s_we), 32'h1);
    check("single t+1 s_addr", 32'(bus.o_s_addr), 32'h1234);
    check("single t+1 s_dat", 32'(bus.o_s_dat), 32'h5A);
    check("single t+1 ack", 32'(bus.o_m_ack), 32'h0);
    step();
    sample();
    check("single wait grant", 32'(bus.o_grant), 32'h2);
    step();
    bus.i_s_ack = 1'b1;
    sample();
    check("single ack", 32'(bus.o_m_ack), 32'h2);
    step();
    bus.i_s_ack = 1'b0;
    bus.i_m_cs  = '0;
    bus.i_m_we  = '0;
    sample();
    check("single idle grant", 32'(bus.o_grant), 32'h0);
    check("single idle s_cs", 32'(bus.o_s_cs), 32'h0);

    // Priority: 0, 0 again (re-request), then 1, then 2.
    do_reset();
    step();
    bus.i_m_cs = 3'b111;
    sample();
    check("prio req grant", 32'(bus.o_grant), 32'h0);
    step();
    bus.i_s_ack = 1'b1;
    sample();
    check("prio g0", 32'(bus.o_grant), 32'h1);
    check("prio ack0", 32'(bus.o_m_ack), 32'h1);
    step();
    bus.i_s_ack = 1'b0;
    sample();
    check("prio dead1", 32'(bus.o_grant), 32'h0);
    step();
    bus.i_s_ack = 1'b1;
    sample();
    check("prio g0 again", 32'(bus.o_grant), 32'h1);
    step();
    bus.i_s_ack = 1'b0;
    bus.i_m_cs  = 3'b110;
    sample();
    check("prio dead2", 32'(bus.o_grant), 32'h0);
    step();
    bus.i_s_ack = 1'b1;
    sample();
    check("prio g1", 32'(bus.o_grant), 32'h2);
    step();
    bus.i_s_ack = 1'b0;
    bus.i_m_cs  = 3'b100;
    sample();
    check("prio dead3", 32'(bus.o_grant), 32'h0);
    step();
    bus.i_s_ack = 1'b1;
    sample();
    check("prio g2", 32'(bus.o_grant), 32'h4);
    check("prio ack2", 32'(bus.o_m_ack), 32'h4);
    step();
    bus.i_s_ack = 1'b0;
    bus.i_m_cs  = '0;
    sample();
    check("prio end grant", 32'(bus.o_grant), 32'h0);

    // Round-robin: masters 1 and 2 request continuously, zero-wait slave.
    do_reset();
    step();
    bus.i_m_cs = 3'b110;
    sample();
    for (int c = 0; c < 8; c++) begin
      step();
      bus.i_s_ack = (rr_exp[c] != '0);
      sample();
      check($sformatf("rr grant c%0d", c), 32'(bus.o_grant), 32'(rr_exp[c]));
      check($sformatf("rr ack c%0d", c), 32'(bus.o_m_ack), 32'(rr_exp[c]));
    end

    // Read data returned to master 2.
    do_reset();
    step();
    bus.i_m_cs = 3'b100;
    step();
    bus.i_s_dat = 8'hC3;
    bus.i_s_ack = 1'b1;
    sample();
    check("read grant", 32'(bus.o_grant), 32'h4);
    check("read m_dat", 32'(bus.o_m_dat), 32'hC3);
    check("read ack", 32'(bus.o_m_ack), 32'h4);
    step();
    bus.i_s_ack = 1'b0;
    bus.i_m_cs  = '0;
    sample();
    check("read idle", 32'(bus.o_grant), 32'h0);

    // Abort: master 1 drops cs while busy.
    do_reset();
    step();
    bus.i_m_cs = 3'b010;
    step();
    sample();
    check("abort grant", 32'(bus.o_grant), 32'h2);
    step();
    bus.i_m_cs = '0;
    sample();
    check("abort ack", 32'(bus.o_m_ack), 32'h0);
    check("abort s_cs", 32'(bus.o_s_cs), 32'h0);
    step();
    sample();
    check("abort idle", 32'(bus.o_grant), 32'h0);

    // Reset while busy.
    step();
    bus.i_m_cs = 3'b010;
    step();
    sample();
    check("rstbusy grant", 32'(bus.o_grant), 32'h2);
    step();
    rst = 1'b1;
    sample();
    check("rstbusy ack", 32'(bus.o_m_ack), 32'h0);
    check("rstbusy err", 32'(bus.o_m_err), 32'h0);
    step();
    rst = 1'b0;
    bus.i_m_cs = '0;
    sample();
    check("rstbusy dropped", 32'(bus.o_grant), 32'h0);

    // Slave never acks; master 2 waits behind master 1.
    do_reset();
    step();
    bus.i_m_cs = 3'b110;
`ifdef BUS_ARBITER_TIMEOUT_EN
    for (int b = 1; b <= 4; b++) begin
      step();
      sample();
      check($sformatf("to grant b%0d", b), 32'(bus.o_grant), 32'h2);
      check($sformatf("to err b%0d", b), 32'(bus.o_m_err), (b == 4) ? 32'h2 : 32'h0);
      check($sformatf("to ack b%0d", b), 32'(bus.o_m_ack), 32'h0);
    end
    step();
    sample();
    check("to released", 32'(bus.o_grant), 32'h0);
    check("to err clear", 32'(bus.o_m_err), 32'h0);
    step();
    sample();
    check("to next grant", 32'(bus.o_grant), 32'h4);
`else
    for (int b = 1; b <= 10; b++) begin
      step();
      sample();
      check($sformatf("hold grant b%0d", b), 32'(bus.o_grant), 32'h2);
      check($sformatf("hold err b%0d", b), 32'(bus.o_m_err), 32'h0);
    end
`endif
    step();
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
